// File: rtl/ds2411_id_ctrl.sv
// ds2411_id_ctrl: sequencer around the DS2411 serial-number reader.
// Pulses the reader's go strobe and waits for done, error or timeout.
// It then validates the returned ROM and retries up to MAX_TRIES attempts.
// It can also launch one identification automatically after reset.
// Optional feature macro: DS2411_CRC_CHECK_EN. When defined, CHECK runs a serial
// Dallas CRC-8 over all 64 ROM bits and tests the family code (0x01). When
// undefined, CHECK takes a single cycle and every completion is accepted.
module ds2411_id_ctrl #(
   parameter int MAX_TRIES  = 3,
   parameter int GO_HOLD    = 200,
   parameter int TIMEOUT    = 2_000_000,
   parameter int RETRY_GAP  = 100_000,
   parameter bit AUTO_START = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        rd_go,
   input  logic        rd_done,
   input  logic        rd_error,
   input  logic [63:0] rd_result,
   output logic        busy,
   output logic        sn_valid,
   output logic        sn_fail,
   output logic [63:0] serial_num,
   output logic [1:0]  fail_code,
   output logic [3:0]  tries
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GO,
      S_WAIT,
      S_CHECK,
      S_GAP,
      S_FIN
   } state_t;

   // Last-count values for the shared phase counter (21 bits covers 20 ms).
   localparam logic [20:0] GO_LAST  = 21'(GO_HOLD - 1);
   localparam logic [20:0] TMO_LAST = 21'(TIMEOUT - 1);
   localparam logic [20:0] GAP_LAST = 21'(RETRY_GAP - 1);

   state_t      state;
   logic        auto_pend;
   logic        done_q;
   logic        err_q;
   logic [20:0] cnt;
   logic [63:0] rom_q;
   logic [63:0] rd_rev;
   logic        done_rise;
   logic        err_rise;
   logic        last_try;
   logic        accept;
   logic        att_fail;
   logic [1:0]  att_code;

`ifdef DS2411_CRC_CHECK_EN
   logic [7:0]  crc_q;

   // One step of the reflected x^8+x^5+x^4+1 CRC, LSB-first data.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[0] ^ din;
      crc8_step = {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
   endfunction
`endif

   assign done_rise = rd_done & ~done_q;
   assign err_rise  = rd_error & ~err_q;
   assign last_try  = (tries == 4'(MAX_TRIES));

   // Reader delivers the first-received bit at [63]; flip so family lands in [7:0].
   always_comb begin
      rd_rev = '0;
      for (int i = 0; i < 64; i++) begin
         rd_rev[i] = rd_result[63 - i];
      end
   end

   // Decide, per cycle, whether the current attempt is accepted or has failed.
   always_comb begin
      accept   = 1'b0;
      att_fail = 1'b0;
      att_code = 2'b00;
      case (state)
         S_WAIT: begin
            if (err_rise) begin
               att_fail = 1'b1;
               att_code = 2'b01;
            end else if (!done_rise && (cnt == TMO_LAST)) begin
               att_fail = 1'b1;
               att_code = 2'b10;
            end
         end
         S_CHECK: begin
`ifdef DS2411_CRC_CHECK_EN
            if (cnt[6]) begin
               if ((crc_q == 8'h00) && (rom_q[7:0] == 8'h01)) begin
                  accept = 1'b1;
               end else begin
                  att_fail = 1'b1;
                  att_code = 2'b11;
               end
            end
`else
            accept = 1'b1;
`endif
         end
         default: begin
            accept   = 1'b0;
            att_fail = 1'b0;
         end
      endcase
   end

   // Completion edge detectors; loaded every cycle so stale levels never count.
   always_ff @(posedge clk) begin
      if (reset) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= rd_done;
         err_q  <= rd_error;
      end
   end

   // Capture the reordered ROM on completion and run the serial CRC across it.
   always_ff @(posedge clk) begin
      if ((state == S_WAIT) && !err_rise && done_rise) begin
         rom_q <= rd_rev;
`ifdef DS2411_CRC_CHECK_EN
         crc_q <= 8'h00;
      end else if ((state == S_CHECK) && !cnt[6]) begin
         crc_q <= crc8_step(crc_q, rom_q[cnt[5:0]]);
`endif
      end
   end

   // Main sequencer: go strobe, wait, check, retry gap and result reporting.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         auto_pend  <= AUTO_START;
         cnt        <= '0;
         rd_go      <= 1'b0;
         busy       <= 1'b0;
         sn_valid   <= 1'b0;
         sn_fail    <= 1'b0;
         serial_num <= '0;
         fail_code  <= 2'b00;
         tries      <= 4'd0;
      end else if (accept) begin
         sn_valid   <= 1'b1;
         serial_num <= rom_q;
         fail_code  <= 2'b00;
         state      <= S_FIN;
      end else if (att_fail) begin
         fail_code <= att_code;
         cnt       <= '0;
         if (last_try) begin
            sn_fail  <= 1'b1;
            sn_valid <= 1'b0;
            state    <= S_FIN;
         end else begin
            state <= S_GAP;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (start || auto_pend) begin
                  auto_pend <= 1'b0;
                  tries     <= 4'd1;
                  sn_fail   <= 1'b0;
                  fail_code <= 2'b00;
                  busy      <= 1'b1;
                  rd_go     <= 1'b1;
                  cnt       <= '0;
                  state     <= S_GO;
               end
            end
            S_GO: begin
               if (cnt == GO_LAST) begin
                  rd_go <= 1'b0;
                  cnt   <= '0;
                  state <= S_WAIT;
               end else begin
                  cnt <= cnt + 21'd1;
               end
            end
            S_WAIT: begin
               if (done_rise) begin
                  cnt   <= '0;
                  state <= S_CHECK;
               end else if (cnt != '1) begin
                  cnt <= cnt + 21'd1;
               end
            end
            S_CHECK: begin
               cnt <= cnt + 21'd1;
            end
            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  rd_go <= 1'b1;
                  tries <= tries + 4'd1;
                  cnt   <= '0;
                  state <= S_GO;
               end else begin
                  cnt <= cnt + 21'd1;
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ds2411_id_ctrl.sv
// tb_ds2411_id_ctrl: directed self-checking bench for ds2411_id_ctrl.
// Expectations follow DS2411_CRC_CHECK_EN the same way the design does.
`timescale 1ns/1ps
module tb_ds2411_id_ctrl;

   localparam int MAX_TRIES = 3;
   localparam int GO_HOLD   = 200;
   localparam int TIMEOUT   = 1000;
   localparam int RETRY_GAP = 50;
`ifdef DS2411_CRC_CHECK_EN
   localparam int LAT_VALID = 66;
   localparam int NA_BAD    = 3;
`else
   localparam int LAT_VALID = 2;
   localparam int NA_BAD    = 1;
`endif
   localparam int T_EXHAUST = MAX_TRIES * (GO_HOLD + TIMEOUT) + (MAX_TRIES - 1) * RETRY_GAP + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        rd_done = 1'b0;
   logic        rd_error = 1'b0;
   logic [63:0] rd_result = '0;
   logic        rd_go;
   logic        busy;
   logic        sn_valid;
   logic        sn_fail;
   logic [63:0] serial_num;
   logic [1:0]  fail_code;
   logic [3:0]  tries;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   ds2411_id_ctrl #(
      .MAX_TRIES (MAX_TRIES),
      .GO_HOLD   (GO_HOLD),
      .TIMEOUT   (TIMEOUT),
      .RETRY_GAP (RETRY_GAP),
      .AUTO_START(1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rd_go     (rd_go),
      .rd_done   (rd_done),
      .rd_error  (rd_error),
      .rd_result (rd_result),
      .busy      (busy),
      .sn_valid  (sn_valid),
      .sn_fail   (sn_fail),
      .serial_num(serial_num),
      .fail_code (fail_code),
      .tries     (tries)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_go(input logic lvl, input string tag);
      for (int i = 0; i < 20000 && rd_go !== lvl; i++) tick();
      check_eq(tag, 64'(rd_go), 64'(lvl));
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 20000) begin
         tick();
         n++;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset_state(input string pfx);
      check_eq({pfx, "_rd_go"},    64'(rd_go),     64'(0));
      check_eq({pfx, "_busy"},     64'(busy),      64'(0));
      check_eq({pfx, "_sn_valid"}, 64'(sn_valid),  64'(0));
      check_eq({pfx, "_sn_fail"},  64'(sn_fail),   64'(0));
      check_eq({pfx, "_serial"},   serial_num,     64'(0));
      check_eq({pfx, "_code"},     64'(fail_code), 64'(0));
      check_eq({pfx, "_tries"},    64'(tries),     64'(0));
   endtask

   // Maxim application-note byte-wise form of the Dallas CRC-8.
   function automatic logic [7:0] dallas_crc(input logic [55:0] d);
      logic [7:0] c;
      c = 8'h00;
      for (int k = 0; k < 7; k++) begin
         c = c ^ d[8*k +: 8];
         for (int j = 0; j < 8; j++) begin
            if (c[0]) c = (c >> 1) ^ 8'h8C;
            else      c = c >> 1;
         end
      end
      return c;
   endfunction

   function automatic logic [63:0] rev64(input logic [63:0] v);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = v[63 - i];
      return r;
   endfunction

   initial begin
      #500_000;
      $display("FAIL global_time_limit: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic [55:0] body;
      logic [63:0] rom_good;
      logic [63:0] rom_bad;
      int          n;
      int          r1;
      int          r2;

      body     = {48'h0000_1234_5678, 8'h01};
      rom_good = {dallas_crc(body), body};
      rom_bad  = rom_good ^ {8'h01, 56'h0};
      r1 = 0;
      r2 = 0;

      // Reset values, then auto-start on the first cycle out of reset
      repeat (3) tick();
      check_reset_state("rst");
      reset = 1'b0;
      tick();
      check_eq("auto_busy",  64'(busy),  64'(1));
      check_eq("auto_rd_go", 64'(rd_go), 64'(1));
      check_eq("auto_tries", 64'(tries), 64'(1));

      // Auto-started request succeeds on the first try
      n = 1;
      while (rd_go === 1'b1 && n < 5000) begin
         tick();
         if (rd_go === 1'b1) n++;
      end
      check_eq("go_hold", 64'(n), 64'(GO_HOLD));
      rd_result = rev64(rom_good);
      rd_done   = 1'b1;
      n = 0;
      while (sn_valid !== 1'b1 && n < 5000) begin
         tick();
         n++;
      end
      check_eq("t1_valid_lat", 64'(n),               64'(LAT_VALID));
      check_eq("t1_serial",    serial_num,           rom_good);
      check_eq("t1_family",    64'(serial_num[7:0]), 64'h01);
      check_eq("t1_tries",     64'(tries),           64'(1));
      check_eq("t1_code",      64'(fail_code),       64'(0));
      check_eq("t1_busy_fin",  64'(busy),            64'(1));
      tick();
      check_eq("t1_busy_fall", 64'(busy), 64'(0));

      // No presence on tries 1 and 2, success on try 3
      rd_done = 1'b0;
      pulse_start();
      check_eq("t2_busy", 64'(busy), 64'(1));
      for (int k = 1; k <= 3; k++) begin
         wait_go(1'b1, "t2_go_rise");
         if (k == 1) r1 = cyc;
         if (k == 2) r2 = cyc;
         wait_go(1'b0, "t2_go_fall");
         if (k < 3) begin
            rd_error = 1'b1;
            tick();
            rd_error = 1'b0;
            check_eq("t2_code01", 64'(fail_code), 64'(1));
         end else begin
            rd_done = 1'b1;
            repeat (LAT_VALID) tick();
         end
      end
      // rise-to-rise: go hold, one WAIT cycle to see the error edge, retry gap
      check_eq("t2_go_spacing", 64'(r2 - r1),   64'(GO_HOLD + RETRY_GAP + 1));
      check_eq("t2_valid",      64'(sn_valid),  64'(1));
      check_eq("t2_tries",      64'(tries),     64'(3));
      check_eq("t2_code",       64'(fail_code), 64'(0));
      pulse_start();
      check_eq("t2_fin_start_ignored", 64'(busy), 64'(0));

      // Reader silent: every try times out
      rd_done = 1'b0;
      pulse_start();
      wait_idle(n);
      check_eq("t3_busy_time", 64'(n),         64'(T_EXHAUST));
      check_eq("t3_sn_fail",   64'(sn_fail),   64'(1));
      check_eq("t3_code",      64'(fail_code), 64'(2));
      check_eq("t3_tries",     64'(tries),     64'(MAX_TRIES));
      check_eq("t3_valid",     64'(sn_valid),  64'(0));

      // CRC byte corrupted on every try
      rd_result = rev64(rom_bad);
      pulse_start();
      for (int k = 1; k <= NA_BAD; k++) begin
         wait_go(1'b1, "t4_go_rise");
         wait_go(1'b0, "t4_go_fall");
         rd_done = 1'b1;
         tick();
         rd_done = 1'b0;
      end
      wait_idle(n);
`ifdef DS2411_CRC_CHECK_EN
      check_eq("t4_sn_fail", 64'(sn_fail),   64'(1));
      check_eq("t4_code",    64'(fail_code), 64'(3));
      check_eq("t4_tries",   64'(tries),     64'(MAX_TRIES));
      check_eq("t4_valid",   64'(sn_valid),  64'(0));
`else
      check_eq("t4_valid",   64'(sn_valid),  64'(1));
      check_eq("t4_sn_fail", 64'(sn_fail),   64'(0));
      check_eq("t4_tries",   64'(tries),     64'(1));
      check_eq("t4_serial",  serial_num,     rom_bad);
`endif

      // Stale rd_done level from a success must not complete the next request
      rd_result = rev64(rom_good);
      pulse_start();
      wait_go(1'b0, "t5_go_fall");
      rd_done = 1'b1;
      wait_idle(n);
      check_eq("t5_first_valid", 64'(sn_valid), 64'(1));
      pulse_start();
      wait_idle(n);
      check_eq("t5_busy_time", 64'(n),         64'(T_EXHAUST));
      check_eq("t5_code",      64'(fail_code), 64'(2));
      check_eq("t5_sn_fail",   64'(sn_fail),   64'(1));

      // Reset while in CHECK, then auto-start relaunch
      rd_done = 1'b0;
      pulse_start();
      wait_go(1'b0, "t6_go_fall");
      rd_done = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      check_reset_state("t6_rst");
      reset = 1'b0;
      tick();
      check_eq("t6_relaunch_busy",  64'(busy),  64'(1));
      check_eq("t6_relaunch_rd_go", 64'(rd_go), 64'(1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
